// File: rtl/memory_bus_arbiter_if.sv
// Request/response bus bundle shared by the host, core and memory sides of memory_bus_arbiter.
// The master drives read/write/address/write_data; the slave returns read_data and a response pulse.
interface memory_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  response;

  modport master (
    output read, write, address, write_data,
    input  read_data, response
  );

  modport slave (
    input  read, write, address, write_data,
    output read_data, response
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Two-port (host/core) arbiter for the single memory bus, with watchdog abort and host lock.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: host priority).
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  memory_bus_arbiter_if.slave  host_bus,
  memory_bus_arbiter_if.slave  core_bus,
  memory_bus_arbiter_if.master mem_bus,
  input  logic                 host_lock,
  output logic                 grant_core,
  output logic                 timeout_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  grant_core_q, grant_core_d;
  logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic                  host_resp_q, host_resp_d;
  logic                  core_resp_q, core_resp_d;
  logic                  timeout_q, timeout_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_core_q, last_core_d;
`endif

  logic host_req_s;
  logic core_req_s;
  logic pick_core_s;
  logic finish_s;

  assign host_req_s = host_bus.read | host_bus.write;
  assign core_req_s = (core_bus.read | core_bus.write) & ~host_lock;

  // Winner selection among eligible requests
  always_comb begin
    pick_core_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (host_req_s && core_req_s) begin
      pick_core_s = ~last_core_q;
    end else begin
      pick_core_s = core_req_s;
    end
`else
    pick_core_s = core_req_s & ~host_req_s;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    grant_core_d  = grant_core_q;
    wd_cnt_d      = wd_cnt_q;
    host_rdata_d  = host_rdata_q;
    core_rdata_d  = core_rdata_q;
    host_resp_d   = 1'b0;
    core_resp_d   = 1'b0;
    timeout_d     = 1'b0;
    finish_s      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_core_d   = last_core_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (host_req_s || core_req_s) begin
          // Write wins when a requester raises both strobes
          if (pick_core_s) begin
            mem_write_d   = core_bus.write;
            mem_read_d    = ~core_bus.write;
            mem_address_d = core_bus.address;
            mem_wdata_d   = core_bus.write_data;
          end else begin
            mem_write_d   = host_bus.write;
            mem_read_d    = ~host_bus.write;
            mem_address_d = host_bus.address;
            mem_wdata_d   = host_bus.write_data;
          end
          grant_core_d = pick_core_s;
          wd_cnt_d     = {CNT_W{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_core_d  = pick_core_s;
`endif
          state_d      = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        finish_s = mem_bus.response | (WD_EN & (wd_cnt_q == CNT_LAST));
        if (finish_s) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          grant_core_d = 1'b0;
          host_resp_d  = ~grant_core_q;
          core_resp_d  = grant_core_q;
          state_d      = ST_DONE;
          if (mem_bus.response) begin
            if (mem_read_q && grant_core_q) begin
              core_rdata_d = mem_bus.read_data;
            end else if (mem_read_q) begin
              host_rdata_d = mem_bus.read_data;
            end else begin
              host_rdata_d = host_rdata_q;
            end
          end else begin
            timeout_d = 1'b1;
            if (grant_core_q) begin
              core_rdata_d = {DATA_WIDTH{1'b1}};
            end else begin
              host_rdata_d = {DATA_WIDTH{1'b1}};
            end
          end
        end else begin
          wd_cnt_d = WD_EN ? wd_cnt_q + CNT_W'(1) : {CNT_W{1'b0}};
          state_d  = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        grant_core_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the strobes immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q   <= {DATA_WIDTH{1'b0}};
      grant_core_q  <= 1'b0;
      wd_cnt_q      <= {CNT_W{1'b0}};
      host_rdata_q  <= {DATA_WIDTH{1'b0}};
      core_rdata_q  <= {DATA_WIDTH{1'b0}};
      host_resp_q   <= 1'b0;
      core_resp_q   <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_core_q   <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      grant_core_q  <= grant_core_d;
      wd_cnt_q      <= wd_cnt_d;
      host_rdata_q  <= host_rdata_d;
      core_rdata_q  <= core_rdata_d;
      host_resp_q   <= host_resp_d;
      core_resp_q   <= core_resp_d;
      timeout_q     <= timeout_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_core_q   <= last_core_d;
`endif
    end
  end

  assign mem_bus.read       = mem_read_q;
  assign mem_bus.write      = mem_write_q;
  assign mem_bus.address    = mem_address_q;
  assign mem_bus.write_data = mem_wdata_q;
  assign host_bus.read_data = host_rdata_q;
  assign host_bus.response  = host_resp_q;
  assign core_bus.read_data = core_rdata_q;
  assign core_bus.response  = core_resp_q;
  assign grant_core         = grant_core_q;
  assign timeout_error      = timeout_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed steps plus randomized transactions
// checked against a transaction-level model of arbitration, watchdog and read-data registers.
`timescale 1ns/1ps
module tb_memory_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic host_lock = 1'b0;
  logic grant_core;
  logic timeout_error;

  memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host_bus ();
  memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) core_bus ();
  memory_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  memory_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .host_bus     (host_bus),
    .core_bus     (core_bus),
    .mem_bus      (mem_bus),
    .host_lock    (host_lock),
    .grant_core   (grant_core),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [DW-1:0] exp_rd [2];   // expected read-data register per port: 0 = host, 1 = core
  bit last_core = 1'b1;        // port granted most recently, as seen by the model

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_hresp"}, host_bus.response, 1'b0);
    chk1({tag, "_cresp"}, core_bus.response, 1'b0);
    chk1({tag, "_tmo"}, timeout_error, 1'b0);
  endtask

  // One complete transaction; lat = WAIT cycle index of mem_response (>= TO means never)
  task automatic run_txn(input bit h_rd, input bit h_wr, input bit c_rd, input bit c_wr,
                         input bit lock, input int lock_hold, input int lat,
                         input logic [31:0] h_a, input logic [31:0] h_d,
                         input logic [31:0] c_a, input logic [31:0] c_d,
                         input logic [31:0] m_d, input bit lock_mid, input bit drop);
    bit h_req, c_elig, core_win, is_wr, to, fin;
    logic [31:0] a, d;
    int k;
    host_bus.read = h_rd; host_bus.write = h_wr; host_bus.address = h_a; host_bus.write_data = h_d;
    core_bus.read = c_rd; core_bus.write = c_wr; core_bus.address = c_a; core_bus.write_data = c_d;
    mem_bus.response = 1'b0;
    if (lock_hold > 0) begin
      host_lock = 1'b1;
      for (int i = 0; i < lock_hold; i++) begin
        @(negedge clk);
        chk1("lock_no_read", mem_bus.read, 1'b0);
        chk1("lock_no_write", mem_bus.write, 1'b0);
      end
    end
    host_lock = lock;
    h_req  = h_rd | h_wr;
    c_elig = (c_rd | c_wr) & ~lock;
    if (h_req && c_elig) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      core_win = ~last_core;
`else
      core_win = 1'b0;
`endif
    end else begin
      core_win = c_elig;
    end
    last_core = core_win;
    is_wr = core_win ? c_wr : h_wr;
    a = core_win ? c_a : h_a;
    d = core_win ? c_d : h_d;

    @(negedge clk);
    chk1("grant", grant_core, core_win);
    chk1("strobe_rd", mem_bus.read, ~is_wr);
    chk1("strobe_wr", mem_bus.write, is_wr);
    chk("mem_addr", a, mem_bus.address);
    if (is_wr) chk("mem_wdata", mem_bus.write_data, d);
    chk_quiet("issue");

    k = 0;
    fin = 1'b0;
    while (!fin) begin
      mem_bus.response  = (k == lat);
      mem_bus.read_data = (k == lat) ? m_d : $urandom;
      if (lock_mid) host_lock = 1'($urandom_range(0, 1));
      if (drop && k == 0) begin
        if (core_win) begin core_bus.read = 1'b0; core_bus.write = 1'b0; end
        else begin host_bus.read = 1'b0; host_bus.write = 1'b0; end
      end
      @(negedge clk);
      if (k == lat || k == TO - 1) begin
        fin = 1'b1;
      end else begin
        chk1("held_rd", mem_bus.read, ~is_wr);
        chk1("held_wr", mem_bus.write, is_wr);
        chk_quiet("wait");
        k++;
      end
    end
    mem_bus.response = 1'b0;
    to = (k != lat);
    if (to) exp_rd[core_win] = '1;
    else if (!is_wr) exp_rd[core_win] = m_d;

    chk1("resp_host", host_bus.response, ~core_win);
    chk1("resp_core", core_bus.response, core_win);
    chk1("timeout_err", timeout_error, to);
    chk1("done_rd_low", mem_bus.read, 1'b0);
    chk1("done_wr_low", mem_bus.write, 1'b0);
    chk1("done_no_grant", grant_core, 1'b0);
    chk("host_rdata", host_bus.read_data, exp_rd[0]);
    chk("core_rdata", core_bus.read_data, exp_rd[1]);

    if (core_win) begin core_bus.read = 1'b0; core_bus.write = 1'b0; end
    else begin host_bus.read = 1'b0; host_bus.write = 1'b0; end
    host_lock = 1'b0;
    @(negedge clk);
    chk_quiet("after_done");
    chk1("after_done_rd", mem_bus.read, 1'b0);
  endtask

  initial begin
    int start;
    host_bus.read = 1'b0; host_bus.write = 1'b0; host_bus.address = '0; host_bus.write_data = '0;
    core_bus.read = 1'b0; core_bus.write = 1'b0; core_bus.address = '0; core_bus.write_data = '0;
    mem_bus.response = 1'b0; mem_bus.read_data = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    repeat (2) @(negedge clk);
    chk1("rst_rd", mem_bus.read, 1'b0);
    chk1("rst_wr", mem_bus.write, 1'b0);
    chk1("rst_grant", grant_core, 1'b0);
    chk("rst_addr", mem_bus.address, 32'h0);
    chk("rst_host_rdata", host_bus.read_data, 32'h0);
    chk("rst_core_rdata", core_bus.read_data, 32'h0);
    chk_quiet("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // simultaneous requests twice: fixed = host,host; round-robin = host,core
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h100, 32'h0, 32'h200, 32'h0, 32'hA5A5_0001, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h104, 32'h0, 32'h204, 32'h0, 32'hA5A5_0002, 1'b0, 1'b0);

    // host read, memory answers three cycles after the strobe
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 32'h10, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // watchdog abort on a core write, then response on the last legal cycle beating the watchdog
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1000, 32'h0, 32'h0, 32'h40, 32'h5555, 32'h0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, TO - 1, 32'h44, 32'h0, 32'h0, 32'h0, 32'h7777_0007, 1'b0, 1'b0);

    // host lock holds off a pending core read for 20 cycles
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20, 1, 32'h0, 32'h0, 32'h80, 32'h0, 32'hC0DE_0080, 1'b0, 1'b0);

    // reset in the middle of a WAIT
    host_bus.read = 1'b1; host_bus.address = 32'h20;
    @(negedge clk);
    chk1("rst_mid_strobe_up", mem_bus.read, 1'b1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk1("rst_mid_async_drop", mem_bus.read, 1'b0);
    host_bus.read = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0; last_core = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_quiet("rst_mid");
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk_quiet("rst_release");
    chk("rst_mid_host_rdata", host_bus.read_data, 32'h0);
    chk("rst_mid_core_rdata", core_bus.read_data, 32'h0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 32'h4, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // back-to-back host reads with same-cycle response: 3 cycles each
    start = cyc;
    for (int i = 0; i < 3; i++)
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'(i * 4), 32'h0, 32'h0, 32'h0, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    chk("b2b_cycles", 32'(cyc - start), 32'd9);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      bit hr, hw, cr, cw, lk;
      int lat;
      hr = 1'($urandom_range(0, 1)); hw = 1'($urandom_range(0, 1));
      cr = 1'($urandom_range(0, 1)); cw = 1'($urandom_range(0, 1));
      lk = ($urandom_range(0, 3) == 0);
      if (!(hr | hw) && (!(cr | cw) || lk)) hr = 1'b1;
      lat = int'($urandom_range(0, 4));
      if (lat == 4) lat = 50;
      run_txn(hr, hw, cr, cw, lk, 0, lat, $urandom, $urandom, $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
